// File: rtl/wb_dma_master_pkg.sv
// Shared definitions for the Wishbone DMA master: FSM encoding, register offsets and CTRL bit positions.
package wb_dma_master_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2
    } state_t;

    // Word offsets, decoded from wb_adr_i[3:2]
    localparam logic [1:0] REG_SRC  = 2'd0;
    localparam logic [1:0] REG_DST  = 2'd1;
    localparam logic [1:0] REG_LEN  = 2'd2;
    localparam logic [1:0] REG_CTRL = 2'd3;

    localparam int CTRL_START = 0;
    localparam int CTRL_BUSY  = 1;
    localparam int CTRL_DONE  = 2;
    localparam int CTRL_ERR   = 3;
    localparam int CTRL_IE    = 4;

endpackage

// File: rtl/wb_dma_master_regs.sv
// Config-register slave for the DMA master: SRC/DST/LEN/CTRL decode, START pulse, DONE/ERR/IE and interrupt.
// Optional feature macro: DMA_IRQ_EN enables the IE bit and the int_o completion interrupt.
module wb_dma_regs
    import wb_dma_master_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_cyc,
    input  logic             i_stb,
    input  logic             i_we,
    input  logic [1:0]       i_adr,
    input  logic [31:0]      i_dat,
    output logic [31:0]      o_dat,
    output logic             o_ack,
    input  logic             i_busy,
    input  logic             i_done_set,
    input  logic             i_err_set,
    output logic [29:0]      o_src,
    output logic [29:0]      o_dst,
    output logic [LEN_W-1:0] o_len,
    output logic             o_start,
    output logic             o_int
);

    logic [29:0]      r_src, r_dst;
    logic [LEN_W-1:0] r_len;
    logic             r_done, r_err, r_ie, r_ack, r_start;
    logic [31:0]      r_dat;

    logic             w_acc, w_wr, w_start;
    logic             w_done_nxt, w_err_nxt, w_ie_nxt;
    logic [31:0]      w_rdata;

    assign w_acc = i_cyc & i_stb & ~r_ack;
    assign w_wr  = w_acc & i_we;

    always_comb begin
        w_rdata = '0;
        case (i_adr)
            REG_SRC: w_rdata = {r_src, 2'b00};
            REG_DST: w_rdata = {r_dst, 2'b00};
            REG_LEN: w_rdata[LEN_W-1:0] = r_len;
            default: begin
                w_rdata[CTRL_BUSY] = i_busy;
                w_rdata[CTRL_DONE] = r_done;
                w_rdata[CTRL_ERR]  = r_err;
                w_rdata[CTRL_IE]   = r_ie;
            end
        endcase
    end

    // Status next-state; completion events from the FSM win over a same-cycle W1C.
    always_comb begin
        w_start    = 1'b0;
        w_done_nxt = r_done;
        w_err_nxt  = r_err;
        w_ie_nxt   = r_ie;
        if (w_wr && i_adr == REG_CTRL) begin
`ifdef DMA_IRQ_EN
            w_ie_nxt = i_dat[CTRL_IE];
`else
            w_ie_nxt = 1'b0;
`endif
            if (i_dat[CTRL_START] && !i_busy) begin
                w_start    = 1'b1;
                w_done_nxt = 1'b0;
                w_err_nxt  = 1'b0;
            end else begin
                if (i_dat[CTRL_DONE]) w_done_nxt = 1'b0;
                if (i_dat[CTRL_ERR])  w_err_nxt  = 1'b0;
            end
        end
        if (i_done_set) w_done_nxt = 1'b1;
        if (i_err_set)  w_err_nxt  = 1'b1;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_src   <= '0;
            r_dst   <= '0;
            r_len   <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
            r_ie    <= 1'b0;
            r_ack   <= 1'b0;
            r_start <= 1'b0;
            r_dat   <= '0;
        end else begin
            r_ack   <= w_acc;
            r_start <= w_start;
            r_done  <= w_done_nxt;
            r_err   <= w_err_nxt;
            r_ie    <= w_ie_nxt;
            if (w_acc) r_dat <= w_rdata;
            if (w_wr && !i_busy) begin
                case (i_adr)
                    REG_SRC: r_src <= i_dat[31:2];
                    REG_DST: r_dst <= i_dat[31:2];
                    REG_LEN: r_len <= i_dat[LEN_W-1:0];
                    default: ;
                endcase
            end
        end
    end

`ifdef DMA_IRQ_EN
    logic r_int;
    always_ff @(posedge i_clk) begin
        if (i_rst) r_int <= 1'b0;
        else       r_int <= w_ie_nxt & w_done_nxt;
    end
    assign o_int = r_int;
`else
    assign o_int = 1'b0;
`endif

    assign o_dat   = r_dat;
    assign o_ack   = r_ack;
    assign o_src   = r_src;
    assign o_dst   = r_dst;
    assign o_len   = r_len;
    assign o_start = r_start;

endmodule

// File: rtl/wb_dma_master.sv
// Single-channel Wishbone DMA: word-by-word read/write copy driven by an IDLE/READ/WRITE FSM.
// Optional feature macro: DMA_IRQ_EN (completion interrupt, handled in wb_dma_regs).
module wb_dma_master
    import wb_dma_master_pkg::*;
#(
    parameter int LEN_W = 16
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        m_cyc_o,
    output logic        m_stb_o,
    output logic        m_we_o,
    output logic [31:0] m_adr_o,
    output logic [31:0] m_dat_o,
    output logic [3:0]  m_sel_o,
    input  logic [31:0] m_dat_i,
    input  logic        m_ack_i,
    input  logic        m_err_i,
    output logic        int_o
);

    state_t           r_state;
    logic [29:0]      r_src_ptr, r_dst_ptr;
    logic [LEN_W-1:0] r_remain;
    logic             r_m_cyc, r_m_stb, r_m_we;
    logic [31:0]      r_m_adr, r_m_dat;
    logic [3:0]       r_m_sel;

    logic [29:0]      w_src, w_dst;
    logic [LEN_W-1:0] w_len;
    logic             w_start, w_busy, w_len_zero, w_last;
    logic             w_done_set, w_err_set;
    logic             w_unused;

    assign w_unused   = &{1'b0, wb_sel_i, wb_adr_i[31:4], wb_adr_i[1:0]};
    assign w_busy     = (r_state != ST_IDLE);
    assign w_len_zero = (w_len == '0);
    assign w_last     = (r_remain == LEN_W'(1));

    // Error beats ack; only a strobed bus cycle can complete or fail.
    assign w_err_set  = r_m_stb & m_err_i;
    assign w_done_set = ((r_state == ST_IDLE) & w_start & w_len_zero)
                      | w_err_set
                      | ((r_state == ST_WRITE) & r_m_stb & m_ack_i & w_last);

    wb_dma_regs #(.LEN_W(LEN_W)) u_regs (
        .i_clk      (wb_clk_i),
        .i_rst      (wb_rst_i),
        .i_cyc      (wb_cyc_i),
        .i_stb      (wb_stb_i),
        .i_we       (wb_we_i),
        .i_adr      (wb_adr_i[3:2]),
        .i_dat      (wb_dat_i),
        .o_dat      (wb_dat_o),
        .o_ack      (wb_ack_o),
        .i_busy     (w_busy),
        .i_done_set (w_done_set),
        .i_err_set  (w_err_set),
        .o_src      (w_src),
        .o_dst      (w_dst),
        .o_len      (w_len),
        .o_start    (w_start),
        .o_int      (int_o)
    );

    // A state entered with strobe low spends one idle cycle as the inter-cycle gap.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            r_state   <= ST_IDLE;
            r_src_ptr <= '0;
            r_dst_ptr <= '0;
            r_remain  <= '0;
            r_m_cyc   <= 1'b0;
            r_m_stb   <= 1'b0;
            r_m_we    <= 1'b0;
            r_m_adr   <= '0;
            r_m_dat   <= '0;
            r_m_sel   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_start && !w_len_zero) begin
                        r_src_ptr <= w_src;
                        r_dst_ptr <= w_dst;
                        r_remain  <= w_len;
                        r_m_cyc   <= 1'b1;
                        r_m_stb   <= 1'b1;
                        r_m_we    <= 1'b0;
                        r_m_sel   <= 4'hF;
                        r_m_adr   <= {w_src, 2'b00};
                        r_state   <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (!r_m_stb) begin
                        r_m_cyc <= 1'b1;
                        r_m_stb <= 1'b1;
                        r_m_we  <= 1'b0;
                        r_m_adr <= {r_src_ptr, 2'b00};
                    end else if (m_err_i) begin
                        r_m_cyc <= 1'b0;
                        r_m_stb <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (m_ack_i) begin
                        r_m_dat <= m_dat_i;
                        r_m_cyc <= 1'b0;
                        r_m_stb <= 1'b0;
                        r_state <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (!r_m_stb) begin
                        r_m_cyc <= 1'b1;
                        r_m_stb <= 1'b1;
                        r_m_we  <= 1'b1;
                        r_m_adr <= {r_dst_ptr, 2'b00};
                    end else if (m_err_i) begin
                        r_m_cyc <= 1'b0;
                        r_m_stb <= 1'b0;
                        r_m_we  <= 1'b0;
                        r_state <= ST_IDLE;
                    end else if (m_ack_i) begin
                        r_m_cyc   <= 1'b0;
                        r_m_stb   <= 1'b0;
                        r_m_we    <= 1'b0;
                        r_remain  <= r_remain - LEN_W'(1);
                        r_src_ptr <= r_src_ptr + 30'd1;
                        r_dst_ptr <= r_dst_ptr + 30'd1;
                        r_state   <= w_last ? ST_IDLE : ST_READ;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign m_cyc_o = r_m_cyc;
    assign m_stb_o = r_m_stb;
    assign m_we_o  = r_m_we;
    assign m_adr_o = r_m_adr;
    assign m_dat_o = r_m_dat;
    assign m_sel_o = r_m_sel;

endmodule
